// File: rtl/one_cycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// one_cycle_control_unit_if
// Groups the sample/timer inputs and the on-time output of the one-cycle
// control unit into a single bundle.
//   sample_current          16  measured inductor current (ADC code)
//   sample_voltage          16  voltage across the inductor during charge
//   timer_buck_4us_0        16  free-running buck period counter
//   i_set                   16  current set-point, same scale as sample_current
//   inductor_charging_time  16  on-time for the current period, clk cycles
// Modports:
//   slave  - the control unit (consumes samples, produces the on-time)
//   master - the surrounding system / testbench
// ---------------------------------------------------------------------------
interface one_cycle_control_unit_if;
  logic [15:0] sample_current;
  logic [15:0] sample_voltage;
  logic [15:0] timer_buck_4us_0;
  logic [15:0] i_set;
  logic [15:0] inductor_charging_time;

  modport slave (
    input  sample_current,
    input  sample_voltage,
    input  timer_buck_4us_0,
    input  i_set,
    output inductor_charging_time
  );

  modport master (
    output sample_current,
    output sample_voltage,
    output timer_buck_4us_0,
    output i_set,
    input  inductor_charging_time
  );
endinterface

// File: rtl/one_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// one_cycle_control_unit
// Computes the buck inductor charging time once per switching period:
//   t_on = (i_set - sample_current) * L_COEF / sample_voltage, clamped to
//   [0, T_MAX]. A calculation starts when the period timer reads 0 while the
//   FSM is idle; the result appears 35 clock edges after that trigger edge.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - one_cycle_control_unit_if.slave (samples, timer, on-time output)
// ---------------------------------------------------------------------------
module one_cycle_control_unit #(
  parameter int unsigned PERIOD = 400,
  parameter int unsigned L_COEF = 100,
  parameter int unsigned T_MAX  = 360
) (
  input  logic                          clk,
  input  logic                          rst,
  one_cycle_control_unit_if.slave       bus
);

  // The clamp may never reach the end of the period, even if the parameters
  // are set inconsistently.
  localparam int unsigned T_LIMIT = (T_MAX < PERIOD) ? T_MAX : (PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DIVIDE,
    OUTPUT
  } state_t;

  state_t      state_q;
  logic [15:0] current_q;
  logic [15:0] voltage_q;
  logic [15:0] iSet_q;
  logic        deltaPos_q;
  logic [31:0] numerator_q;
  logic [31:0] quo_q;
  logic [15:0] rem_q;
  logic [5:0]  count_q;
  logic [15:0] chargeTime_q;

  logic [16:0] deltaFull;
  logic        deltaPos;
  logic [31:0] product;
  logic [16:0] shifted;
  logic        trialOk;
  logic [15:0] remDiff;
  logic [15:0] result_d;

  // Set-point error and scaled numerator from the latched samples. The error
  // is taken 17 bits wide so a current above the set-point shows up as a
  // negative value instead of wrapping.
  always_comb begin
    deltaFull = {1'b0, iSet_q} - {1'b0, current_q};
    deltaPos  = !deltaFull[16] && (deltaFull != 17'd0);
    product   = 32'(deltaFull[15:0]) * 32'(L_COEF);
  end

  // One restoring-division step. The remainder is always below the 16-bit
  // divisor, so the shifted partial remainder fits in 17 bits and a
  // successful subtraction fits back into 16 bits.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trialOk = (shifted >= {1'b0, voltage_q});
    remDiff = shifted[15:0] - voltage_q;
  end

  // Final clamp: no positive error means no on-time; a zero voltage with a
  // positive error would divide by zero, so it saturates to the limit.
  always_comb begin
    result_d = 16'd0;
    if (!deltaPos_q) begin
      result_d = 16'd0;
    end else if (voltage_q == 16'd0) begin
      result_d = 16'(T_LIMIT);
    end else if (quo_q > 32'(T_LIMIT)) begin
      result_d = 16'(T_LIMIT);
    end else begin
      result_d = quo_q[15:0];
    end
  end

  // Control FSM plus datapath registers. DIVIDE spends its first cycle
  // loading the divider (count 0) and then runs 32 quotient-bit steps
  // (count 1..32); the timer is only looked at while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      current_q    <= 16'd0;
      voltage_q    <= 16'd0;
      iSet_q       <= 16'd0;
      deltaPos_q   <= 1'b0;
      numerator_q  <= 32'd0;
      quo_q        <= 32'd0;
      rem_q        <= 16'd0;
      count_q      <= 6'd0;
      chargeTime_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.timer_buck_4us_0 == 16'd0) begin
            current_q <= bus.sample_current;
            voltage_q <= bus.sample_voltage;
            iSet_q    <= bus.i_set;
            state_q   <= CAPTURE;
          end
        end
        CAPTURE: begin
          deltaPos_q  <= deltaPos;
          numerator_q <= deltaPos ? product : 32'd0;
          count_q     <= 6'd0;
          state_q     <= DIVIDE;
        end
        DIVIDE: begin
          if (count_q == 6'd0) begin
            quo_q <= numerator_q;
            rem_q <= 16'd0;
          end else begin
            quo_q <= {quo_q[30:0], trialOk};
            rem_q <= trialOk ? remDiff : shifted[15:0];
          end
          count_q <= count_q + 6'd1;
          if (count_q == 6'd32) begin
            state_q <= OUTPUT;
          end
        end
        OUTPUT: begin
          chargeTime_q <= result_d;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.inductor_charging_time = chargeTime_q;

endmodule

// File: tb/tb_one_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_one_cycle_control_unit
// Directed testbench for one_cycle_control_unit: drives a 0..399 period
// timer and sample values, and compares the registered on-time against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_one_cycle_control_unit;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;
  bit          timerRun;
  logic [15:0] timerHoldVal;

  one_cycle_control_unit_if ifc ();

  one_cycle_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Period timer: counts 0..399 when running, otherwise holds a chosen value.
  // It moves just after the rising edge so it is stable when the DUT samples.
  initial begin
    ifc.timer_buck_4us_0 = 16'd5;
    forever begin
      @(posedge clk);
      #1;
      if (timerRun) begin
        ifc.timer_buck_4us_0 = (ifc.timer_buck_4us_0 >= 16'd399) ? 16'd0
                               : ifc.timer_buck_4us_0 + 16'd1;
      end else begin
        ifc.timer_buck_4us_0 = timerHoldVal;
      end
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive a new set of samples on the falling edge.
  task automatic applyStimulus(input logic [15:0] iSet, input logic [15:0] cur,
                               input logic [15:0] volt);
    @(negedge clk);
    ifc.i_set          = iSet;
    ifc.sample_current = cur;
    ifc.sample_voltage = volt;
  endtask

  // Wait (bounded) until the timer shows the given value at a falling edge.
  task automatic waitTimer(input logic [15:0] value);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ifc.timer_buck_4us_0 != value) && (n < 1000));
    checkOutput("timer_reach", 32'(ifc.timer_buck_4us_0), 32'(value));
  endtask

  // Load samples mid-period, let the next period's calculation finish, check.
  task automatic runPeriod(input string tag, input logic [15:0] iSet,
                           input logic [15:0] cur, input logic [15:0] volt,
                           input logic [15:0] expected);
    waitTimer(16'd200);
    applyStimulus(iSet, cur, volt);
    waitTimer(16'd100);
    checkOutput(tag, 32'(ifc.inductor_charging_time), 32'(expected));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    timerRun     = 1'b0;
    timerHoldVal = 16'd5;
    rst          = 1'b1;
    ifc.i_set          = 16'($urandom);
    ifc.sample_current = 16'($urandom);
    ifc.sample_voltage = 16'($urandom);

    // Reset with random inputs, including a timer sitting at 0
    repeat (5) @(negedge clk);
    checkOutput("reset_out", 32'(ifc.inductor_charging_time), 32'd0);
    timerHoldVal = 16'd0;
    repeat (10) @(negedge clk);
    checkOutput("reset_timer0", 32'(ifc.inductor_charging_time), 32'd0);
    timerHoldVal = 16'd5;
    repeat (3) @(negedge clk);

    // Release with the timer held away from 0: nothing may start
    rst = 1'b0;
    applyStimulus(16'd60, 16'd0, 16'd25);
    repeat (500) @(negedge clk);
    checkOutput("hold_nonzero", 32'(ifc.inductor_charging_time), 32'd0);

    // Basic period: 60*100/25 = 240
    timerRun = 1'b1;
    waitTimer(16'd0);
    waitTimer(16'd100);
    checkOutput("basic_240", 32'(ifc.inductor_charging_time), 32'd240);

    // Current steps with exact latency check: 45*100/25 = 180
    waitTimer(16'd200);
    applyStimulus(16'd60, 16'd15, 16'd25);
    waitTimer(16'd0);
    repeat (35) @(negedge clk);
    checkOutput("latency_hold", 32'(ifc.inductor_charging_time), 32'd240);
    @(negedge clk);
    checkOutput("latency_update", 32'(ifc.inductor_charging_time), 32'd180);
    runPeriod("step_120", 16'd60, 16'd30, 16'd25, 16'd120);

    // Current at or above the set-point gives zero, then recovers
    runPeriod("equal_0",   16'd60, 16'd60, 16'd25, 16'd0);
    runPeriod("above_0",   16'd60, 16'd75, 16'd25, 16'd0);
    runPeriod("back_120",  16'd60, 16'd30, 16'd25, 16'd120);

    // Clamp, divide-by-zero, limit boundaries, truncation, full width
    runPeriod("clamp_600",  16'd60,    16'd0,  16'd10,    16'd360);
    runPeriod("vzero",      16'd60,    16'd0,  16'd0,     16'd360);
    runPeriod("vzero_neg",  16'd10,    16'd20, 16'd0,     16'd0);
    runPeriod("exact_tmax", 16'd36,    16'd0,  16'd10,    16'd360);
    runPeriod("tmax_plus1", 16'd361,   16'd0,  16'd100,   16'd360);
    runPeriod("below_tmax", 16'd359,   16'd0,  16'd100,   16'd359);
    runPeriod("trunc_176",  16'd60,    16'd30, 16'd17,    16'd176);
    runPeriod("wide_100",   16'hFFFF,  16'd0,  16'hFFFF,  16'd100);

    // Inputs changing during a calculation must not disturb it
    waitTimer(16'd200);
    applyStimulus(16'd60, 16'd30, 16'd25);
    waitTimer(16'd10);
    applyStimulus(16'd60, 16'd0, 16'd1);
    waitTimer(16'd100);
    checkOutput("latched_120", 32'(ifc.inductor_charging_time), 32'd120);
    waitTimer(16'd200);
    waitTimer(16'd100);
    checkOutput("next_360", 32'(ifc.inductor_charging_time), 32'd360);

    // Reset in the middle of the divider, then a clean recompute
    runPeriod("pre_reset", 16'd60, 16'd15, 16'd25, 16'd180);
    waitTimer(16'd200);
    applyStimulus(16'd60, 16'd30, 16'd25);
    waitTimer(16'd15);
    rst = 1'b1;
    #1;
    checkOutput("reset_async", 32'(ifc.inductor_charging_time), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitTimer(16'd0);
    waitTimer(16'd100);
    checkOutput("after_reset_120", 32'(ifc.inductor_charging_time), 32'd120);

    // Timer stalled at 0: a new calculation starts every time the FSM idles
    waitTimer(16'd200);
    applyStimulus(16'd60, 16'd15, 16'd25);
    timerHoldVal = 16'd0;
    timerRun     = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("stall_180", 32'(ifc.inductor_charging_time), 32'd180);
    applyStimulus(16'd60, 16'd30, 16'd25);
    repeat (80) @(negedge clk);
    checkOutput("stall_restart_120", 32'(ifc.inductor_charging_time), 32'd120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
